// File: rtl/turbo_frame_packer.sv
// rtl/turbo_frame_packer.sv - serial hard-decision bits packed into 7-bit frames
// behind a 2-entry output queue for the deinterleaver.

module frame_fifo2 (
   input  logic       clk_p_i,
   input  logic       reset_n_i,
   input  logic       push,
   input  logic [6:0] push_data,
   input  logic       pop,
   output logic [6:0] head,
   output logic [1:0] count
);

   logic [6:0] tail;

   // head is the registered output word; it only moves on push-into-empty or pop.
   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head  <= 7'b0;
         tail  <= 7'b0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) head <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

module turbo_frame_packer (
   input  logic       clk_p_i,
   input  logic       reset_n_i,
   input  logic       bit_i,
   input  logic       bit_valid_i,
   input  logic       sof_i,
   output logic       bit_ready_o,
   output logic [6:0] frame_o,
   output logic       frame_valid_o,
   input  logic       frame_ready_i,
   output logic       sync_err_o,
   output logic [7:0] frame_cnt_o
);

   typedef enum logic {
      HUNT = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t     state;
   logic [2:0] idx;
   logic [5:0] partial;
   logic [1:0] fifo_count;
   logic       bit_acc;
   logic       frame_acc;
   logic       push;
   logic [6:0] push_frame;

   assign bit_ready_o   = (fifo_count != 2'd2);
   assign frame_valid_o = (fifo_count != 2'd0);
   assign bit_acc       = bit_valid_i & bit_ready_o;
   assign frame_acc     = frame_valid_o & frame_ready_i;

   // The seventh bit goes straight into the queue without passing through partial.
   assign push       = bit_acc & (state == FILL) & (idx == 3'd6) & ~sof_i;
   assign push_frame = {bit_i, partial};

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state      <= HUNT;
         idx        <= 3'd0;
         partial    <= 6'b0;
         sync_err_o <= 1'b0;
      end else begin
         sync_err_o <= 1'b0;
         if (bit_acc) begin
            if (sof_i) begin
               partial    <= {5'b0, bit_i};
               idx        <= 3'd1;
               state      <= FILL;
               sync_err_o <= (state == FILL) && (idx != 3'd0);
            end else if (state == FILL) begin
               if (idx == 3'd6) begin
                  idx <= 3'd0;
               end else begin
                  partial[idx] <= bit_i;
                  idx          <= idx + 3'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) frame_cnt_o <= 8'd0;
      else if (frame_acc) frame_cnt_o <= frame_cnt_o + 8'd1;
   end

   frame_fifo2 u_fifo (
      .clk_p_i   (clk_p_i),
      .reset_n_i (reset_n_i),
      .push      (push),
      .push_data (push_frame),
      .pop       (frame_acc),
      .head      (frame_o),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_turbo_frame_packer.sv
// tb/tb_turbo_frame_packer.sv - directed bench with a queue-level model of
// frame alignment, output buffering and the frame counter.

module tb_turbo_frame_packer;

   logic       clk_p = 1'b0;
   logic       reset_n = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       sof = 1'b0;
   logic       frame_ready = 1'b0;
   logic       bit_ready_o;
   logic [6:0] frame_o;
   logic       frame_valid_o;
   logic       sync_err_o;
   logic [7:0] frame_cnt_o;

   always #5 clk_p = ~clk_p;

   turbo_frame_packer dut (
      .clk_p_i       (clk_p),
      .reset_n_i     (reset_n),
      .bit_i         (bit_in),
      .bit_valid_i   (bit_valid),
      .sof_i         (sof),
      .bit_ready_o   (bit_ready_o),
      .frame_o       (frame_o),
      .frame_valid_o (frame_valid_o),
      .frame_ready_i (frame_ready),
      .sync_err_o    (sync_err_o),
      .frame_cnt_o   (frame_cnt_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: expected values of DUT outputs at the next falling edge.
   logic [6:0] mq[$];
   bit         cur[$];
   bit         aligned;
   bit         err_exp;
   logic [7:0] cnt_exp;
   logic [6:0] last_exp;
   logic [6:0] dut_log[$];
   int         err_seen = 0;

   always @(negedge clk_p) begin
      logic [6:0] f;
      bit         newf;
      bit         rdy;
      if (!reset_n) begin
         mq.delete();
         cur.delete();
         aligned  = 0;
         err_exp  = 0;
         cnt_exp  = 8'd0;
         last_exp = 7'd0;
      end
      check("m_valid", frame_valid_o, mq.size() != 0);
      check("m_ready", bit_ready_o, mq.size() < 2);
      check("m_frame", frame_o, (mq.size() != 0) ? mq[0] : last_exp);
      check("m_err", sync_err_o, err_exp);
      check("m_cnt", frame_cnt_o, cnt_exp);
      if (frame_valid_o && frame_ready) dut_log.push_back(frame_o);
      if (sync_err_o) err_seen++;
      if (reset_n) begin
         rdy     = mq.size() < 2;
         newf    = 0;
         err_exp = 0;
         if (bit_valid && rdy) begin
            if (sof) begin
               if (aligned && cur.size() != 0) err_exp = 1;
               cur.delete();
               cur.push_back(bit_in);
               aligned = 1;
            end else if (aligned) begin
               cur.push_back(bit_in);
               if (cur.size() == 7) begin
                  for (int i = 0; i < 7; i++) f[i] = cur[i];
                  newf = 1;
                  cur.delete();
               end
            end
         end
         if (mq.size() != 0 && frame_ready) begin
            void'(mq.pop_front());
            cnt_exp = cnt_exp + 8'd1;
         end
         if (newf) mq.push_back(f);
         if (mq.size() != 0) last_exp = mq[0];
      end
   end

   task automatic send_bit(input logic b, input logic s);
      int waited = 0;
      bit done = 0;
      bit_in = b;
      sof = s;
      bit_valid = 1'b1;
      while (!done) begin
         @(negedge clk_p);
         done = bit_ready_o;
         @(posedge clk_p);
         #1;
         waited++;
         if (!done && waited > 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bit_stall_timeout: got stalled expected accept at %0t", $time);
            done = 1;
         end
      end
      bit_valid = 1'b0;
      sof = 1'b0;
   endtask

   task automatic send_frame(input logic [6:0] f, input logic with_sof);
      for (int i = 0; i < 7; i++) send_bit(f[i], with_sof && (i == 0));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_p);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk_p);
      #1 reset_n = 1'b0;
      @(posedge clk_p);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      int base;
      logic [6:0] fb;
      repeat (2) @(posedge clk_p);
      #1;
      check("rst_ready", bit_ready_o, 1);
      check("rst_valid", frame_valid_o, 0);
      check("rst_frame", frame_o, 7'd0);
      check("rst_cnt", frame_cnt_o, 8'd0);
      check("rst_err", sync_err_o, 0);
      reset_n = 1'b1;
      frame_ready = 1'b1;

      // first frame: bits 1,0,1,1,0,0,1
      send_frame(7'b1001101, 1'b1);
      check("lat_valid", frame_valid_o, 1);
      check("lat_frame", frame_o, 7'b1001101);
      idle(1);
      check("first_cnt", frame_cnt_o, 8'd1);
      check("first_log_n", dut_log.size(), 1);
      check("first_log", dut_log[0], 7'b1001101);

      // unaligned bits are dropped in HUNT
      do_reset();
      send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
      send_frame(7'h7f, 1'b1);
      idle(2);
      check("hunt_log_n", dut_log.size(), 2);
      check("hunt_log", dut_log[1], 7'h7f);

      // sof on the fourth bit restarts the frame
      base = err_seen;
      send_bit(0, 1); send_bit(1, 0); send_bit(1, 0);
      send_frame(7'b0101001, 1'b1);
      idle(2);
      check("resync_err", err_seen - base, 1);
      check("resync_log_n", dut_log.size(), 3);
      check("resync_log", dut_log[2], 7'b0101001);
      check("resync_cnt", frame_cnt_o, 8'd2);

      // back-pressure: two frames fill the queue, third stalls
      frame_ready = 1'b0;
      send_frame(7'h15, 1'b0);
      send_frame(7'h6a, 1'b0);
      check("full_ready", bit_ready_o, 0);
      check("full_head", frame_o, 7'h15);
      fork
         send_frame(7'h33, 1'b0);
         begin
            idle(6);
            check("stall_ready", bit_ready_o, 0);
            check("stall_head", frame_o, 7'h15);
            frame_ready = 1'b1;
         end
      join
      idle(4);
      check("bp_log_n", dut_log.size(), 6);
      check("bp_log0", dut_log[3], 7'h15);
      check("bp_log1", dut_log[4], 7'h6a);
      check("bp_log2", dut_log[5], 7'h33);

      // push and pop on the same edge with one frame buffered
      frame_ready = 1'b0;
      send_frame(7'h0c, 1'b0);
      fb = 7'h52;
      for (int i = 0; i < 6; i++) send_bit(fb[i], 0);
      frame_ready = 1'b1;
      send_bit(fb[6], 0);
      check("pp_valid", frame_valid_o, 1);
      check("pp_head", frame_o, 7'h52);
      idle(2);
      check("pp_log", dut_log[dut_log.size() - 1], 7'h52);
      check("pp_log_prev", dut_log[dut_log.size() - 2], 7'h0c);

      // counter wrap
      do_reset();
      for (int k = 0; k < 255; k++) send_frame(7'(k * 37), k == 0);
      idle(2);
      check("cnt_255", frame_cnt_o, 8'd255);
      send_frame(7'h2d, 1'b0);
      idle(2);
      check("cnt_wrap", frame_cnt_o, 8'd0);

      // asynchronous reset with two frames buffered
      frame_ready = 1'b0;
      send_frame(7'h11, 1'b1);
      send_frame(7'h22, 1'b0);
      check("pre_rst_valid", frame_valid_o, 1);
      @(posedge clk_p);
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid", frame_valid_o, 0);
      check("arst_ready", bit_ready_o, 1);
      check("arst_frame", frame_o, 7'd0);
      @(posedge clk_p);
      #2 reset_n = 1'b1;
      frame_ready = 1'b1;
      base = dut_log.size();
      send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
      idle(3);
      check("post_rst_none", dut_log.size(), base);
      send_frame(7'h7e, 1'b1);
      idle(2);
      check("post_rst_n", dut_log.size(), base + 1);
      check("post_rst_frame", dut_log[dut_log.size() - 1], 7'h7e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
